// File: rtl/msg_bridge_pkg.sv
// msg_bridge_pkg: shared types, ASCII bounds and the per-field case transform
// for msg_echo_bridge.
//   mode_t      : transform select (pass / toggle case / force upper / force lower)
//   state_t     : transmit FSM states
//   xform_field : transforms one field value; callers zero-extend fields to XF_W
//                 bits and truncate the result back (fields up to 32 bits wide).
package msg_bridge_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_LOWER  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SEND  = 2'b01,
        ST_GUARD = 2'b10
    } state_t;

    localparam int unsigned XF_W = 32;

    localparam logic [XF_W-1:0] ASCII_UPPER_LO = 32'h41;
    localparam logic [XF_W-1:0] ASCII_UPPER_HI = 32'h5A;
    localparam logic [XF_W-1:0] ASCII_LOWER_LO = 32'h61;
    localparam logic [XF_W-1:0] ASCII_LOWER_HI = 32'h7A;
    localparam logic [XF_W-1:0] CASE_DELTA     = 32'h20;

    // Only letters are ever shifted by CASE_DELTA, so no value can wrap.
    function automatic logic [XF_W-1:0] xform_field(input logic [XF_W-1:0] value,
                                                    input mode_t           mode);
        logic            is_upper;
        logic            is_lower;
        logic [XF_W-1:0] result;
        is_upper = (value >= ASCII_UPPER_LO) && (value <= ASCII_UPPER_HI);
        is_lower = (value >= ASCII_LOWER_LO) && (value <= ASCII_LOWER_HI);
        result   = value;
        case (mode)
            MODE_TOGGLE: begin
                if (is_upper)      result = value + CASE_DELTA;
                else if (is_lower) result = value - CASE_DELTA;
            end
            MODE_UPPER: begin
                if (is_lower) result = value - CASE_DELTA;
            end
            MODE_LOWER: begin
                if (is_upper) result = value + CASE_DELTA;
            end
            default: result = value;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// msg_fifo: synchronous FIFO, registered count, no fall-through.
//   clock, reset      : clock and asynchronous active-high reset
//   push, push_data   : write request; ignored when full (fullness is the
//                       pre-pop state of this cycle)
//   pop               : read request; ignored when empty
//   head              : oldest entry (valid when !empty)
//   full, empty, count: status derived from the registered count
module msg_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/msg_echo_bridge.sv
// msg_echo_bridge: buffered bridge from UART receiver to transmitter.
// Received messages are queued, each non-tag field gets the selected ASCII
// case transform at pop time, and the result is presented to the transmitter
// with a one-cycle isNew_out pulse followed by a guard interval.
//   clock, reset            : clock, asynchronous active-high reset
//   isNew_in, message_in    : receiver pulse and message
//   mode                    : 00 pass, 01 toggle, 10 upper, 11 lower
//   ready                   : transmitter idle
//   isNew_out, message_out  : transmit pulse and held message
//   overflow, clear_ovf     : sticky drop flag and its clear (set wins)
//   occupancy               : FIFO count
//   msg_count, drop_count   : saturating statistics; real counters only when
//                             MSG_BRIDGE_STATS_EN is defined, otherwise 0
module msg_echo_bridge
    import msg_bridge_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 5,
    parameter int unsigned FIELD_W    = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GUARD      = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          isNew_in,
    input  logic [NUM_FIELDS*FIELD_W-1:0] message_in,
    input  logic [1:0]                    mode,
    input  logic                          ready,
    output logic                          isNew_out,
    output logic [NUM_FIELDS*FIELD_W-1:0] message_out,
    output logic                          overflow,
    input  logic                          clear_ovf,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [15:0]                   msg_count,
    output logic [15:0]                   drop_count
);

    localparam int unsigned MSG_W      = NUM_FIELDS * FIELD_W;
    localparam int unsigned GCW        = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GCW-1:0] GUARD_LOAD = GCW'((GUARD > 0) ? GUARD - 1 : 0);

    logic [MSG_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_req;
    logic             drop;
    logic             pop;
    logic [MSG_W-1:0] xform_msg;

    state_t           state_q, state_d;
    logic [GCW-1:0]   guard_cnt_q, guard_cnt_d;
    logic             is_new_q, is_new_d;
    logic [MSG_W-1:0] message_q, message_d;
    logic             overflow_q, overflow_d;

    assign push_req = isNew_in;
    assign drop     = isNew_in && fifo_full;

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (message_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // Field 0 is the tag and is copied through untouched.
    always_comb begin
        xform_msg = fifo_head;
        for (int unsigned f = 1; f < NUM_FIELDS; f++) begin
            xform_msg[f*FIELD_W +: FIELD_W] =
                FIELD_W'(xform_field(XF_W'(fifo_head[f*FIELD_W +: FIELD_W]), mode_t'(mode)));
        end
    end

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        is_new_d    = 1'b0;
        message_d   = message_q;
        pop         = 1'b0;
        overflow_d  = overflow_q;

        if (drop)           overflow_d = 1'b1;
        else if (clear_ovf) overflow_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ready && !fifo_empty) begin
                    pop       = 1'b1;
                    message_d = xform_msg;
                    is_new_d  = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (GUARD == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                // Leave when the decremented count reaches zero; a load of
                // zero (GUARD=1) leaves after a single guard cycle.
                if (guard_cnt_q <= GCW'(1)) begin
                    state_d     = ST_IDLE;
                    guard_cnt_d = '0;
                end else begin
                    guard_cnt_d = guard_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            guard_cnt_q <= '0;
            is_new_q    <= 1'b0;
            message_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            is_new_q    <= is_new_d;
            message_q   <= message_d;
            overflow_q  <= overflow_d;
        end
    end

    assign isNew_out   = is_new_q;
    assign message_out = message_q;
    assign overflow    = overflow_q;

`ifdef MSG_BRIDGE_STATS_EN
    logic [15:0] msg_count_q, msg_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        msg_count_d  = msg_count_q;
        drop_count_d = drop_count_q;
        if (is_new_d && (msg_count_q != 16'hFFFF))  msg_count_d  = msg_count_q + 1'b1;
        if (drop && (drop_count_q != 16'hFFFF))     drop_count_d = drop_count_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msg_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            msg_count_q  <= msg_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign msg_count  = msg_count_q;
    assign drop_count = drop_count_q;
`else
    assign msg_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_msg_echo_bridge.sv
// Directed testbench for msg_echo_bridge (default geometry: 5 fields x 8 bits,
// DEPTH 4, GUARD 2). Statistics expectations follow MSG_BRIDGE_STATS_EN.
module tb_msg_echo_bridge;

`ifdef MSG_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        isNew_in;
    logic [39:0] message_in;
    logic [1:0]  mode;
    logic        ready;
    logic        isNew_out;
    logic [39:0] message_out;
    logic        overflow;
    logic        clear_ovf;
    logic [2:0]  occupancy;
    logic [15:0] msg_count;
    logic [15:0] drop_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [39:0] fill_msgs [6];

    always #5 clock = ~clock;

    msg_echo_bridge #(
        .NUM_FIELDS (5),
        .FIELD_W    (8),
        .DEPTH      (4),
        .GUARD      (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .isNew_in    (isNew_in),
        .message_in  (message_in),
        .mode        (mode),
        .ready       (ready),
        .isNew_out   (isNew_out),
        .message_out (message_out),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf),
        .occupancy   (occupancy),
        .msg_count   (msg_count),
        .drop_count  (drop_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push one message with ready=1 from an idle, empty bridge and check the
    // pulse two edges later, then let the guard interval expire.
    task automatic send_one(input string tag, input logic [1:0] m,
                            input logic [39:0] msg, input logic [39:0] exp);
        mode       = m;
        isNew_in   = 1'b1;
        message_in = msg;
        step();
        isNew_in   = 1'b0;
        chk({tag, "_nopulse"}, 64'(isNew_out), 64'd0);
        chk({tag, "_occ1"}, 64'(occupancy), 64'd1);
        step();
        chk({tag, "_pulse"}, 64'(isNew_out), 64'd1);
        chk({tag, "_msg"}, 64'(message_out), 64'(exp));
        step();
        chk({tag, "_single"}, 64'(isNew_out), 64'd0);
        chk({tag, "_hold"}, 64'(message_out), 64'(exp));
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        isNew_in   = 1'b0;
        message_in = '0;
        mode       = 2'b00;
        ready      = 1'b0;
        clear_ovf  = 1'b0;
        step();
        step();
        chk("rst_isnew", 64'(isNew_out), 64'd0);
        chk("rst_msg", 64'(message_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_msgcnt", 64'(msg_count), 64'd0);
        chk("rst_dropcnt", 64'(drop_count), 64'd0);
        reset = 1'b0;
        ready = 1'b1;
        step();

        // Transforms, tag preservation and letter-range boundaries
        send_one("toggle", 2'b01, 40'h48656C6C07, 40'h68454C4C07);
        send_one("upper",  2'b10, 40'h61315A7A03, 40'h41315A5A03);
        send_one("lower",  2'b11, 40'h41315A5A03, 40'h61317A7A03);
        send_one("pass",   2'b00, 40'h4161007A05, 40'h4161007A05);
        send_one("tag",    2'b01, 40'h2041617A41, 40'h2061415A41);
        send_one("bounds", 2'b01, 40'h405B607B00, 40'h405B607B00);

        // Overflow with ready low, then FIFO-order drain at GUARD+1 spacing
        fill_msgs[0] = 40'h1111111101;
        fill_msgs[1] = 40'h2222222202;
        fill_msgs[2] = 40'h3333333303;
        fill_msgs[3] = 40'h4444444404;
        fill_msgs[4] = 40'h5555555505;
        fill_msgs[5] = 40'h6666666606;
        mode  = 2'b00;
        ready = 1'b0;
        chk("ovf_pre", 64'(overflow), 64'd0);
        isNew_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            message_in = fill_msgs[i];
            step();
            chk("fill_occ", 64'(occupancy), (i < 4) ? 64'(i + 1) : 64'd4);
        end
        isNew_in = 1'b0;
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_dropcnt", 64'(drop_count), STATS ? 64'd2 : 64'd0);
        ready = 1'b1;
        step();
        chk("drain0_pulse", 64'(isNew_out), 64'd1);
        chk("drain0_msg", 64'(message_out), 64'(fill_msgs[0]));
        chk("drain0_occ", 64'(occupancy), 64'd3);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("drain_gap1", 64'(isNew_out), 64'd0);
            step();
            chk("drain_gap2", 64'(isNew_out), 64'd0);
            step();
            chk("drain_pulse", 64'(isNew_out), 64'd1);
            chk("drain_msg", 64'(message_out), 64'(fill_msgs[k]));
        end
        step();
        step();
        chk("drain_msgcnt", 64'(msg_count), STATS ? 64'd10 : 64'd0);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("clear_ovf", 64'(overflow), 64'd0);

        // Full FIFO: clear vs drop priority, and push-while-full with pop
        ready    = 1'b0;
        isNew_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            message_in = fill_msgs[i];
            step();
        end
        chk("full_occ", 64'(occupancy), 64'd4);
        message_in = 40'hDEADBEEF01;
        step();
        chk("full_drop_ovf", 64'(overflow), 64'd1);
        message_in = 40'hDEADBEEF02;
        clear_ovf  = 1'b1;
        step();
        chk("set_wins_ovf", 64'(overflow), 64'd1);
        isNew_in = 1'b0;
        step();
        clear_ovf = 1'b0;
        chk("clear_only_ovf", 64'(overflow), 64'd0);
        ready      = 1'b1;
        isNew_in   = 1'b1;
        message_in = 40'hDEADBEEF03;
        step();
        isNew_in = 1'b0;
        chk("poppush_occ", 64'(occupancy), 64'd3);
        chk("poppush_ovf", 64'(overflow), 64'd1);
        chk("poppush_pulse", 64'(isNew_out), 64'd1);
        chk("poppush_msg", 64'(message_out), 64'(fill_msgs[0]));
        repeat (12) step();
        chk("full_drain_occ", 64'(occupancy), 64'd0);
        chk("full_drain_msg", 64'(message_out), 64'(fill_msgs[3]));
        chk("full_dropcnt", 64'(drop_count), STATS ? 64'd5 : 64'd0);
        chk("full_msgcnt", 64'(msg_count), STATS ? 64'd14 : 64'd0);

        // Reset during GUARD with two entries still queued
        ready    = 1'b0;
        isNew_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            message_in = fill_msgs[i + 3];
            step();
        end
        isNew_in = 1'b0;
        ready    = 1'b1;
        step();
        chk("rg_pulse", 64'(isNew_out), 64'd1);
        step();
        chk("rg_guard_occ", 64'(occupancy), 64'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("rg_isnew", 64'(isNew_out), 64'd0);
        chk("rg_msg", 64'(message_out), 64'd0);
        chk("rg_occ", 64'(occupancy), 64'd0);
        chk("rg_ovf", 64'(overflow), 64'd0);
        chk("rg_msgcnt", 64'(msg_count), 64'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rg_quiet", 64'(isNew_out), 64'd0);
        end

        // Ready toggling around SEND/GUARD, and mode sampled only at pop
        mode       = 2'b01;
        isNew_in   = 1'b1;
        message_in = 40'h6162434401;
        step();
        message_in = 40'h6162434402;
        step();
        isNew_in = 1'b0;
        chk("rt_pulse1", 64'(isNew_out), 64'd1);
        chk("rt_msg1", 64'(message_out), 64'h4142636401);
        chk("rt_occ", 64'(occupancy), 64'd1);
        ready = 1'b0;
        mode  = 2'b10;
        step();
        chk("rt_guard", 64'(isNew_out), 64'd0);
        chk("rt_msg1_hold", 64'(message_out), 64'h4142636401);
        ready = 1'b1;
        step();
        chk("rt_idle", 64'(isNew_out), 64'd0);
        step();
        chk("rt_pulse2", 64'(isNew_out), 64'd1);
        chk("rt_msg2", 64'(message_out), 64'h4142434402);
        step();
        step();
        chk("rt_msgcnt", 64'(msg_count), STATS ? 64'd2 : 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
